// File: rtl/dequantize_stream_pkg.sv
// -----------------------------------------------------------------------------
// dequantize_stream_pkg
// Shared widths and lane types for the int8 <-> int32 quantization blocks.
//   Q8_W      : width of one int8 activation lane
//   ACC_W     : width of one accumulator-domain lane
//   DIFF_W    : width of (q - zero_point); 9 bits hold -255..255 without wrap
//   SHIFT_MAX : largest left shift that keeps a 9-bit difference inside ACC_W
// -----------------------------------------------------------------------------
package dequantize_stream_pkg;

    localparam int Q8_W      = 8;
    localparam int ACC_W     = 32;
    localparam int DIFF_W    = 9;
    localparam int SHIFT_MAX = 23;

    typedef logic signed [Q8_W-1:0]   q8_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DIFF_W-1:0] diff_t;

endpackage

// File: rtl/dequantize_stream_lane.sv
// -----------------------------------------------------------------------------
// dequant_lane
// Combinational arithmetic for one lane, split in the two halves the pipeline
// registers between:
//   front half : o_diff = sext9(i_q) - sext9(i_zero_point)
//   back half  : o_acc  = sext32(i_diff) << SHIFT
// Ports:
//   i_q          [7:0]  signed int8 activation
//   i_zero_point [7:0]  signed int8 zero point
//   o_diff       [8:0]  signed difference, feeds the stage-1 register
//   i_diff       [8:0]  registered difference from stage 1
//   o_acc        [31:0] shifted accumulator-domain value, feeds stage 2
// -----------------------------------------------------------------------------
module dequant_lane
    import dequantize_stream_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic [Q8_W-1:0]   i_q,
    input  logic [Q8_W-1:0]   i_zero_point,
    output logic [DIFF_W-1:0] o_diff,
    input  logic [DIFF_W-1:0] i_diff,
    output logic [ACC_W-1:0]  o_acc
);

    logic [ACC_W-1:0] w_ext;

    // One extra sign bit on each operand means the subtraction cannot wrap.
    assign o_diff = {i_q[Q8_W-1], i_q} - {i_zero_point[Q8_W-1], i_zero_point};

    assign w_ext  = {{(ACC_W-DIFF_W){i_diff[DIFF_W-1]}}, i_diff};
    assign o_acc  = w_ext << SHIFT;

endmodule

// File: rtl/dequantize_stream.sv
// -----------------------------------------------------------------------------
// dequantize_stream
// Expands SIZE signed int8 lanes into the 32-bit accumulator domain:
//   pixel_out[i] = sext32(q[i] - zero_point) << SHIFT
// Two-stage elastic pipeline, full throughput, no skid buffer.
// Handshake: a beat moves across an interface on a rising clock edge where
// valid and ready are both high; valid/data/last never change while
// valid is high and ready is low.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   pixel_in  [8*SIZE]    lane i = pixel_in[8i+7:8i]
//   zero_point[8]         captured with each accepted beat
//   in_last               end-of-frame marker, travels with the beat
//   out_valid / out_ready downstream handshake
//   pixel_out [32*SIZE]   lane i = pixel_out[32i+31:32i]
//   out_last              in_last of the presented beat
// -----------------------------------------------------------------------------
module dequantize_stream
    import dequantize_stream_pkg::*;
#(
    parameter int SHIFT = 8,
    parameter int SIZE  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Q8_W*SIZE-1:0]    pixel_in,
    input  logic [Q8_W-1:0]         zero_point,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W*SIZE-1:0]   pixel_out,
    output logic                    out_last
);

    generate
        if (SHIFT < 0 || SHIFT > SHIFT_MAX) begin : g_bad_shift
            $error("dequantize_stream: SHIFT must be within 0..23");
        end
    endgenerate

    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic [DIFF_W*SIZE-1:0]   r_s1_diff;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [ACC_W*SIZE-1:0]    r_pixel_out;

    logic                     w_s1_ready;
    logic                     w_s2_ready;
    logic [DIFF_W*SIZE-1:0]   w_diff;
    logic [ACC_W*SIZE-1:0]    w_acc;

    // Purely combinational ready chain: a full pipeline accepts a new beat in
    // the same cycle the output beat leaves.
    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        dequant_lane #(
            .SHIFT (SHIFT)
        ) u_lane (
            .i_q          (pixel_in[Q8_W*g +: Q8_W]),
            .i_zero_point (zero_point),
            .o_diff       (w_diff[DIFF_W*g +: DIFF_W]),
            .i_diff       (r_s1_diff[DIFF_W*g +: DIFF_W]),
            .o_acc        (w_acc[ACC_W*g +: ACC_W])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_diff   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pixel_out <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= in_valid;
                r_s1_last  <= in_last;
                r_s1_diff  <= w_diff;
            end
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_last;
                r_pixel_out <= w_acc;
            end
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign pixel_out = r_pixel_out;

endmodule

// File: tb/tb_dequantize_stream.sv
module tb_dequantize_stream;

    localparam int EW = 1 + 256 + 256;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [63:0]  pixel_in;
    logic [7:0]   zero_point;
    logic         in_last;
    logic         out_ready;

    logic         in_ready,  in_ready_23;
    logic         out_valid, out_valid_23;
    logic [255:0] pixel_out, pixel_out_23;
    logic         out_last,  out_last_23;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    int            in_cyc[$];
    int            out_cyc[$];

    logic          prev_hold = 1'b0;
    logic [255:0]  prev_pix;
    logic          prev_last;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    dequantize_stream #(.SHIFT(8), .SIZE(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .zero_point(zero_point), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
        .out_last(out_last)
    );

    dequantize_stream #(.SHIFT(23), .SIZE(8)) dut23 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_23),
        .pixel_in(pixel_in), .zero_point(zero_point), .in_last(in_last),
        .out_valid(out_valid_23), .out_ready(out_ready), .pixel_out(pixel_out_23),
        .out_last(out_last_23)
    );

    // ---------------- reference model ----------------
    function automatic logic [255:0] model(input logic [63:0] pix, input logic [7:0] zp,
                                           input int sh);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int q, z, d;
            q = int'($signed(pix[8*i +: 8]));
            z = int'($signed(zp));
            d = q - z;
            r[32*i +: 32] = 32'(d * (1 << sh));
        end
        return r;
    endfunction

    // ---------------- checks ----------------
    task automatic chk_b(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_v(input string tag, input logic [255:0] o, input logic [255:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            chk_b("shift23_valid_match", out_valid_23, out_valid);
            chk_b("shift23_ready_match", in_ready_23, in_ready);
            if (prev_hold) begin
                chk_b("hold_valid", out_valid, 1'b1);
                chk_v("hold_pixel", pixel_out, prev_pix);
                chk_b("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_output: observed=%h expected=none", pixel_out);
                end
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk_b("sb_last", out_last, e[EW-1]);
                    chk_v("sb_pixel_s8", pixel_out, e[511:256]);
                    chk_v("sb_pixel_s23", pixel_out_23, e[255:0]);
                end
            end
            if (in_valid && in_ready) begin
                in_cyc.push_back(cyc);
                exp_q.push_back({in_last, model(pixel_in, zero_point, 8),
                                 model(pixel_in, zero_point, 23)});
            end
            prev_hold = out_valid && !out_ready;
            prev_pix  = pixel_out;
            prev_last = out_last;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 just after the beat was taken.
    task automatic put_beat(input logic [63:0] pix, input logic [7:0] zp, input logic last);
        int  n;
        bit  done;
        logic ok;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        pixel_in = pix;
        zero_point = zp;
        in_last = last;
        while (!done) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            if (ok) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    chk_b("put_beat_timeout", 1'b0, 1'b1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 20);
        chk_b("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic wait_outs(input int cnt);
        int t;
        t = 0;
        while (out_cyc.size() < cnt && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk_w("out_count", 32'(out_cyc.size()), 32'(cnt));
    endtask

    function automatic logic [63:0] splat(input logic [7:0] v);
        return {8{v}};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        pixel_in = '0;
        zero_point = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // reset state
        @(negedge clock);
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_v("rst_pixel", pixel_out, '0);
        chk_b("rst_last", out_last, 1'b0);
        @(posedge clock); #1;

        // single beat, latency 2, valid for one cycle
        put_beat({48'h0, 8'h80, 8'h7F}, 8'h00, 1'b0);
        @(negedge clock);
        chk_b("t1_not_yet", out_valid, 1'b0);
        @(negedge clock);
        chk_b("t1_valid", out_valid, 1'b1);
        chk_w("t1_lane0", pixel_out[31:0], 32'h00007F00);
        chk_w("t1_lane1", pixel_out[63:32], 32'hFFFF8000);
        @(negedge clock);
        chk_b("t1_one_cycle", out_valid, 1'b0);
        @(posedge clock); #1;

        // zero-point and extreme values
        put_beat(splat(8'h80), 8'd5, 1'b0);
        wait_out();
        chk_w("zp5_q80", pixel_out[31:0], 32'hFFFF7B00);
        @(posedge clock); #1;
        put_beat(splat(8'h7F), 8'h80, 1'b0);
        wait_out();
        chk_w("zp80_q7f_s8", pixel_out[31:0], 32'h0000FF00);
        chk_w("zp80_q7f_s23", pixel_out_23[31:0], 32'h7F800000);
        @(posedge clock); #1;
        put_beat(splat(8'h80), 8'h7F, 1'b0);
        wait_out();
        chk_w("zp7f_q80_s8", pixel_out[31:0], 32'hFFFF0100);
        chk_w("zp7f_q80_s23", pixel_out_23[31:0], 32'h80800000);
        @(posedge clock); #1;

        // stalled stream of 6 beats
        out_ready = 1'b0;
        out_cyc.delete();
        put_beat(splat(8'd1), 8'h00, 1'b0);
        put_beat(splat(8'd2), 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk_b("stall_in_ready_low", in_ready, 1'b0);
            chk_b("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            put_beat(splat(8'(k)), 8'h00, k == 6);
        end
        wait_outs(6);
        for (int i = 1; i < out_cyc.size(); i++) begin
            chk_w("stream_no_gap", 32'(out_cyc[i]), 32'(out_cyc[i-1] + 1));
        end
        @(posedge clock); #1;

        // full throughput, random data and zero points
        out_cyc.delete();
        in_cyc.delete();
        for (int k = 0; k < 16; k++) begin
            put_beat({$urandom, $urandom}, 8'($urandom_range(0, 255)), k == 15);
        end
        wait_outs(16);
        chk_w("tp_latency", 32'(out_cyc[0]), 32'(in_cyc[0] + 2));
        for (int i = 1; i < out_cyc.size(); i++) begin
            chk_w("tp_out_consec", 32'(out_cyc[i]), 32'(out_cyc[i-1] + 1));
            chk_w("tp_in_consec", 32'(in_cyc[i]), 32'(in_cyc[i-1] + 1));
        end
        @(posedge clock); #1;

        // reset with both stages full
        out_ready = 1'b0;
        put_beat(splat(8'h11), 8'h01, 1'b0);
        put_beat(splat(8'h22), 8'h02, 1'b1);
        @(negedge clock);
        chk_b("pre_rst_full", in_ready, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        out_cyc.delete();
        @(negedge clock);
        chk_b("mid_rst_out_valid", out_valid, 1'b0);
        chk_v("mid_rst_pixel", pixel_out, '0);
        chk_v("mid_rst_pixel_s23", pixel_out_23, '0);
        chk_b("mid_rst_last", out_last, 1'b0);
        chk_b("mid_rst_in_ready", in_ready, 1'b1);
        repeat (4) @(negedge clock);
        chk_w("no_stale_beats", 32'(out_cyc.size()), 32'd0);
        @(posedge clock); #1;
        put_beat({8'h80, 8'h7F, 8'h01, 8'hFF, 8'h40, 8'hC0, 8'h00, 8'h03}, 8'hFD, 1'b1);
        wait_outs(1);

        repeat (3) @(negedge clock);
        chk_w("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dequantize_stream.md
Name: dequantize_stream

Overview:
Expands a vector of SIZE signed int8 activations back into the 32-bit fixed-point accumulator domain. It computes (q - zero_point) << SHIFT per lane, sign-extended to 32 bits. It is the inverse-direction counterpart of the 32-to-8 requantize stage and feeds 8-bit layer outputs or external int8 input into 32-bit adders and accumulators. The datapath is a 2-stage elastic pipeline with valid/ready handshake and full throughput.

Parameters:
SHIFT, 8, left shift applied after zero-point subtraction; legal range 0..23, so the 9-bit difference always fits in 32 bits signed.
SIZE, 8, number of lanes per beat.

Ports:
clock  input  1  sole clock; all state updates on its rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat this cycle
pixel_in  input  8*SIZE  lane i = pixel_in[8i+7:8i], signed int8
zero_point  input  8  signed int8; sampled together with each accepted beat
in_last  input  1  end-of-frame marker; travels with the beat
out_valid  output  1  pixel_out/out_last valid
out_ready  input  1  downstream accepts
pixel_out  output  32*SIZE  lane i = pixel_out[32i+31:32i], signed 32-bit
out_last  output  1  in_last of the beat currently presented

Behaviour:
- Transfer on an interface happens when valid && ready are both high at a rising edge.
- Stage 1 (s1) registers, per lane, d[i] = sext9(q[i]) - sext9(zero_point). The result is 9-bit signed, range -255..255, with no wrap. s1 also holds s1_valid and s1_last.
- Stage 2 (s2) registers pixel_out[i] = sext32(d[i]) << SHIFT. s2 holds out_valid and out_last. Low SHIFT bits are zero.
- Ready chain:
  - s2_ready = !out_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
  - The chain is combinational; there is no skid buffer.
- Stage loading:
  - s1 loads when in_ready.
  - s1_valid <= in_valid when in_ready; otherwise it holds.
  - s2 loads from s1 when s2_ready; out_valid <= s1_valid in that case.
- Data and last bits in a stage hold whenever that stage is not loading. Outputs stay stable while out_valid && !out_ready (AXI-style hold).
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Backpressure: with out_ready low, the pipeline fills (2 beats) and then in_ready drops in the same cycle. Once out_ready rises, in_ready is high combinationally in that cycle, with no bubble.
- Simultaneous events: while full and out_ready=1, a new beat is accepted in the same cycle as the output beat; there is no loss and no duplication.
- zero_point is captured per beat, so changing it between beats affects only later beats.
- Reset (synchronous, any cycle, including mid-stream) clears:
  - s1_valid, out_valid, out_last, s1_last
  - all s1 data
  - pixel_out to 0
  In-flight beats are dropped. in_ready is 1 in the first cycle after reset deasserts. Reset has priority over loading.
- Out-of-range SHIFT (>23) is a compile-time error via generate-time check.

Decomposition:
- The shared quant package holds:
  - Q8_W=8, ACC_W=32, DIFF_W=9
  - SHIFT_MAX=23
  - the signed lane typedefs q8_t and acc_t
- Sub-module dequant_lane is purely combinational: the sub/shift arithmetic for one lane, instantiated SIZE times in a generate loop. Pipeline registers and handshake stay in the top.

Test Plan:
- SHIFT=8, zp=0, lane0 q=0x7F, lane1 q=0x80, out_ready=1 -> after 2 cycles, lane0=0x00007F00 and lane1=0xFFFF8000, out_valid for exactly 1 cycle.
- SHIFT=8, zp=5, q=0x80 -> 0xFFFF7B00; zp=0x80 (-128), q=0x7F -> 0x0000FF00.
- SHIFT=23, zp=0x80, q=0x7F -> 0x7F800000; zp=0x7F, q=0x80 -> 0x80800000. No overflow at the extremes.
- Stream of 6 beats (values 1..6, in_last on beat 6) with out_ready low for cycles 3-6:
  - in_ready drops after 2 beats are held.
  - out_valid/pixel_out stay stable while stalled.
  - All 6 beats emerge in order, out_last only on beat 6, with no gaps once out_ready=1.
- Continuous in_valid=1, out_ready=1 for 16 beats -> 16 outputs on 16 consecutive cycles starting at cycle 2.
- Reset asserted for 1 cycle with both stages full -> next cycle out_valid=0, pixel_out=0, in_ready=1; the stale beats never appear on the output.
